// File: rtl/mult_array_if.sv
// Operand/product bundle for mult_array: operands plus qualifier in, registered product plus valid out.
interface mult_array_if #(
  parameter int unsigned WIDTH = 2
);
  logic                 in_valid;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   P;
  logic                 out_valid;

  modport master (output in_valid, a, b, input P, out_valid);
  modport slave  (input in_valid, a, b, output P, out_valid);
endinterface

// File: rtl/mult_array.sv
// mult_array: unsigned array multiplier (half/full-adder grid) with registered product and valid flag.
// Define MULT_ARRAY_PIPE_EN to register the array after row ceil(WIDTH/2)-1 (latency 2 instead of 1).
module mult_array #(
  parameter int unsigned WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_array_if.slave bus
);

`ifdef MULT_ARRAY_PIPE_EN
  localparam int unsigned H = (WIDTH + 1) / 2;

  logic [H+WIDTH-1:0] sum_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-H-1:0] b_hi_q;
  logic               v1_q;
`endif

  logic [2*WIDTH-1:0] p_q;
  logic               out_valid_q;
  logic               load;

  // Row i holds the running sum of pp[0..i]; its width grows by one bit per row.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [i+WIDTH:0] sum;

    if (i == 0) begin : g_first
      assign sum = {1'b0, bus.a & {WIDTH{bus.b[0]}}};
    end else begin : g_add
      logic [i+WIDTH-1:0] acc;
      logic [WIDTH-1:0]   pp;
      logic [WIDTH-1:0]   s;
      logic [WIDTH:1]     c;

`ifdef MULT_ARRAY_PIPE_EN
      if (i >= H) begin : g_late
        if (i == H) begin : g_cut
          assign acc = sum_q;
        end else begin : g_chain
          assign acc = g_row[i-1].sum;
        end
        assign pp = a_q & {WIDTH{b_hi_q[i-H]}};
      end else begin : g_early
        assign acc = g_row[i-1].sum;
        assign pp  = bus.a & {WIDTH{bus.b[i]}};
      end
`else
      assign acc = g_row[i-1].sum;
      assign pp  = bus.a & {WIDTH{bus.b[i]}};
`endif

      assign s[0] = acc[i] ^ pp[0];
      assign c[1] = acc[i] & pp[0];

      for (genvar j = 1; j < WIDTH; j++) begin : g_fa
        assign s[j]   = acc[i+j] ^ pp[j] ^ c[j];
        assign c[j+1] = (acc[i+j] & pp[j]) | (c[j] & (acc[i+j] ^ pp[j]));
      end

      assign sum = {c[WIDTH], s, acc[i-1:0]};
    end
  end

`ifdef MULT_ARRAY_PIPE_EN
  // Mid-array cut: keep the partial sum plus the operand bits the later rows still need.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      a_q    <= '0;
      b_hi_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q  <= g_row[H-1].sum;
        a_q    <= bus.a;
        b_hi_q <= bus.b[WIDTH-1:H];
      end
    end
  end

  assign load = v1_q;
`else
  assign load = bus.in_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= load;
      if (load) begin
        p_q <= g_row[WIDTH-1].sum;
      end
    end
  end

  assign bus.P         = p_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mult_array.sv
// Self-checking bench for mult_array: WIDTH=2 and WIDTH=8 instances against a queue-based a*b reference.
module tb_mult_array;

`ifdef MULT_ARRAY_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef struct {
    bit          v;
    int unsigned p;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;

  mult_array_if #(.WIDTH(2)) bus2 ();
  mult_array_if #(.WIDTH(8)) bus8 ();

  mult_array #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  mult_array #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int checks   = 0;
  int failures = 0;

  txn_t        q2[$];
  txn_t        q8[$];
  int unsigned ep2 = 0;
  int unsigned ep8 = 0;
  bit          ev2 = 1'b0;
  bit          ev8 = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_P2"},  {28'd0, bus2.P},        ep2);
    chk({tag, "_ov2"}, {31'd0, bus2.out_valid}, {31'd0, ev2});
    chk({tag, "_P8"},  {16'd0, bus8.P},        ep8);
    chk({tag, "_ov8"}, {31'd0, bus8.out_valid}, {31'd0, ev8});
  endtask

  task automatic model_reset();
    q2.delete();
    q8.delete();
    ep2 = 0;
    ep8 = 0;
    ev2 = 1'b0;
    ev8 = 1'b0;
  endtask

  task automatic drive(input logic [1:0] a2, input logic [1:0] b2, input logic v2,
                       input logic [7:0] a8, input logic [7:0] b8, input logic v8);
    bus2.a = a2; bus2.b = b2; bus2.in_valid = v2;
    bus8.a = a8; bus8.b = b8; bus8.in_valid = v8;
  endtask

  // One clock: record what was sampled, then compare outputs 1 time unit after the edge.
  task automatic step(input string tag);
    txn_t t2, t8;
    @(posedge clk);
    if (rst_n === 1'b1) begin
      t2.v = bus2.in_valid;
      t2.p = int'(bus2.a) * int'(bus2.b);
      t8.v = bus8.in_valid;
      t8.p = int'(bus8.a) * int'(bus8.b);
      q2.push_back(t2);
      q8.push_back(t8);
      if (q2.size() > LAT) void'(q2.pop_front());
      if (q8.size() > LAT) void'(q8.pop_front());
    end
    #1;
    if (q2.size() == LAT) begin
      ev2 = q2[0].v;
      if (q2[0].v) ep2 = q2[0].p;
    end else begin
      ev2 = 1'b0;
    end
    if (q8.size() == LAT) begin
      ev8 = q8[0].v;
      if (q8[0].v) ep8 = q8[0].p;
    end else begin
      ev8 = 1'b0;
    end
    check_all(tag);
  endtask

  int unsigned ca[4] = '{255, 0, 128, 1};
  int unsigned cb[4] = '{255, 200, 2, 173};

  initial begin
    // Reset held with valid operands and a running clock.
    rst_n = 1'b0;
    drive(2'd3, 2'd3, 1'b1, 8'd3, 8'd3, 1'b1);
    model_reset();
    #1;
    check_all("rst_async");
    repeat (3) step("in_reset");

    // Release between edges; 3*3 = 9 must emerge after the configured latency.
    #3 rst_n = 1'b1;
    repeat (LAT + 1) step("first_9");
    chk("first_9_const_P2", {28'd0, bus2.P}, 32'd9);
    chk("first_9_const_P8", {16'd0, bus8.P}, 32'd9);

    // Exhaustive 2-bit sweep: b every cycle, a every 4 cycles.
    for (int k = 0; k < 16; k++) begin
      drive(2'(k / 4), 2'(k % 4), 1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1);
      step("exhaustive");
    end

    // 8-bit corner operands.
    for (int k = 0; k < 4; k++) begin
      drive(2'($urandom_range(3)), 2'($urandom_range(3)), 1'b1, 8'(ca[k]), 8'(cb[k]), 1'b1);
      step("corner");
    end
    repeat (LAT) begin
      drive(2'd0, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0);
      step("corner_drain");
    end
    chk("corner_last_P8", {16'd0, bus8.P}, 32'd173);

    // Hold: a valid 3*2 followed by bubbles with operands toggling.
    drive(2'd3, 2'd2, 1'b1, 8'd3, 8'd2, 1'b1);
    step("hold_load");
    for (int k = 0; k < 4; k++) begin
      if (k == 3) drive('x, 'x, 1'b0, 'x, 'x, 1'b0);
      else drive(2'($urandom_range(3)), 2'($urandom_range(3)), 1'b0,
                 8'($urandom_range(255)), 8'($urandom_range(255)), 1'b0);
      step("hold");
    end
    chk("hold_const_P2", {28'd0, bus2.P}, 32'd6);
    chk("hold_const_P8", {16'd0, bus8.P}, 32'd6);

    // Random stream with occasional bubbles.
    for (int k = 0; k < 200; k++) begin
      drive(2'($urandom_range(3)), 2'($urandom_range(3)), 1'($urandom_range(3) != 0),
            8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(3) != 0));
      step("random");
    end

    // Back-to-back full-rate stream.
    for (int k = 0; k < 40; k++) begin
      drive(2'($urandom_range(3)), 2'($urandom_range(3)), 1'b1,
            8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1);
      step("b2b");
    end

    // Reset pulse between edges in the middle of a valid stream.
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst_async");
    #2 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive(2'($urandom_range(3)), 2'($urandom_range(3)), 1'b1,
            8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(4) != 0));
      step("post_midrst");
    end

    drive(2'd0, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) step("flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
